// File: rtl/outmap_pkg.sv
// outmap_pkg: shared byte/window types and the compressor window width for the output-map stager
package outmap_pkg;
  localparam int OUTMAP_WIN = 16;
  typedef logic [7:0] omap_byte_t;
  typedef omap_byte_t [15:0] omap_win_t;
endpackage

// File: rtl/outmap_win_rotator.sv
// outmap_win_rotator: rotates the circular byte store so the window starts at rd_ptr
// ports: mem (whole store), rd_ptr (oldest byte) -> win (WIN bytes, entry 0 oldest), pure combinational
module outmap_win_rotator
  import outmap_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIN   = OUTMAP_WIN
) (
  input  omap_byte_t [DEPTH-1:0]         mem,
  input  logic [$clog2(DEPTH)-1:0]       rd_ptr,
  output omap_byte_t [WIN-1:0]           win
);
  localparam int PW = $clog2(DEPTH);
  always_comb begin
    win = '0;
    for (int k = 0; k < WIN; k++) win[k] = mem[rd_ptr + PW'(k)];
  end
endmodule

// File: rtl/outmap_stager.sv
// outmap_stager: byte staging buffer feeding the compressor a left-aligned 16-byte window
// ports: clk, rst (async high); in_valid/in_ready/in_data/in_num/in_last input beats;
//        outmap_data/outmap_data_valid_num/start window to compressor; valid_taken_num bytes consumed;
//        frame_done last byte of a map retired; err_overtake sticky over-consumption flag
module outmap_stager
  import outmap_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int IN_BYTES = 8,
  parameter int WIN      = OUTMAP_WIN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_BYTES*8-1:0]       in_data,
  input  logic [$clog2(IN_BYTES):0]   in_num,
  input  logic                        in_last,
  output logic [WIN-1:0][7:0]         outmap_data,
  output logic [$clog2(WIN):0]        outmap_data_valid_num,
  output logic                        start,
  input  logic [$clog2(WIN):0]        valid_taken_num,
  output logic                        frame_done,
  output logic                        err_overtake
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int VW = $clog2(WIN) + 1;
  localparam logic [CW-1:0] ROOM = CW'(DEPTH - IN_BYTES);
  omap_byte_t [DEPTH-1:0] mem;
  omap_byte_t [WIN-1:0] raw;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic [VW-1:0] valid_num, taken;
  logic last_seen, first, push;
  assign in_ready = !last_seen && count <= ROOM;
  assign push = in_valid && in_ready;
  // short windows only while draining a finished map, so the compressor flushes early only at map end
  assign valid_num = count >= CW'(WIN) ? VW'(WIN) : last_seen ? VW'(count) : '0;
  assign taken = valid_taken_num > valid_num ? valid_num : valid_taken_num;
  assign count_next = count - CW'(taken) + (push ? CW'(in_num) : '0);
  assign frame_done = last_seen && count_next == '0;
  assign start = first && valid_num != '0;
  assign outmap_data_valid_num = valid_num;
  outmap_win_rotator #(.DEPTH(DEPTH), .WIN(WIN)) u_rot (.mem(mem), .rd_ptr(rd_ptr), .win(raw));
  always_comb begin
    outmap_data = '0;
    for (int k = 0; k < WIN; k++) outmap_data[k] = VW'(k) < valid_num ? raw[k] : 8'h00;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_BYTES; i++)
      if (push && i < int'(in_num)) mem[wr_ptr + PW'(i)] <= in_data[i*8 +: 8];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      last_seen <= 1'b0;
      first <= 1'b1;
      err_overtake <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(taken);
      wr_ptr <= push ? wr_ptr + PW'(in_num) : wr_ptr;
      count <= count_next;
      last_seen <= frame_done ? 1'b0 : (push && in_last) ? 1'b1 : last_seen;
      first <= frame_done ? 1'b1 : start ? 1'b0 : first;
      err_overtake <= err_overtake || valid_taken_num > valid_num;
    end
  end
endmodule
